// File: rtl/mdu_pkg.sv
// Shared MDU definitions: operation encodings, default latencies and the
// helper that classifies an opcode as a multi-cycle multiply/divide.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_md_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// E-stage operand/result bundle between the pipeline datapath and the MDU.
interface mdu_if;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  mdu_op;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mdu_out;

  modport master (output a, b, mdu_op, input start, busy, hi, lo, mdu_out);
  modport slave  (input a, b, mdu_op, output start, busy, hi, lo, mdu_out);
endinterface

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath producing the 64-bit {HI,LO} result
// for MULT/MULTU/DIV/DIVU, plus a divide-by-zero flag.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  mdu_op,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] b_safe;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_s;
  logic [31:0] r_s;

  // Sign-extended operands multiplied modulo 2^64 give the signed product.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide on magnitudes keeps 0x80000000 / -1 well defined.
  assign b_safe = (b == 32'd0) ? 32'd1 : b;
  assign abs_a  = a[31] ? (~a + 32'd1) : a;
  assign abs_b  = b_safe[31] ? (~b_safe + 32'd1) : b_safe;
  assign q_mag  = abs_a / abs_b;
  assign r_mag  = abs_a % abs_b;
  assign q_s    = (a[31] ^ b_safe[31]) ? (~q_mag + 32'd1) : q_mag;
  assign r_s    = a[31] ? (~r_mag + 32'd1) : r_mag;

  assign div_by_zero = ((mdu_op == MDU_DIV) || (mdu_op == MDU_DIVU)) && (b == 32'd0);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    result = 64'd0;
    case (mdu_op)
      MDU_MULT:  result = prod_s;
      MDU_MULTU: result = prod_u;
      MDU_DIV:   result = {r_s, q_s};
      MDU_DIVU:  result = {b_safe == 32'd0 ? 32'd0 : a % b_safe, a / b_safe};
      default:   result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// E-stage multiply/divide unit: owns HI/LO, models fixed mult/div latency
// with a busy counter and serves mfhi/mflo through mdu_out.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  logic [CW-1:0] count;
  logic          busy_q;
  logic [31:0]   hi_q, lo_q, temp_hi, temp_lo;
  logic [63:0]   calc_result;
  logic          calc_dbz;
  logic          is_mult;

  mdu_calc u_calc (
    .a           (bus.a),
    .b           (bus.b),
    .mdu_op      (bus.mdu_op),
    .result      (calc_result),
    .div_by_zero (calc_dbz)
  );

  assign is_mult = (bus.mdu_op == MDU_MULT) || (bus.mdu_op == MDU_MULTU);

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      temp_hi <= 32'd0;
      temp_lo <= 32'd0;
      count   <= '0;
      busy_q  <= 1'b0;
    end else if (count == CW'(1)) begin
      hi_q   <= temp_hi;
      lo_q   <= temp_lo;
      count  <= '0;
      busy_q <= 1'b0;
    end else if (count > CW'(1)) begin
      count <= count - CW'(1);
    end else if (!busy_q) begin
      if (is_md_op(bus.mdu_op)) begin
        // A divide by zero retires the current HI/LO, leaving them unchanged.
        temp_hi <= calc_dbz ? hi_q : calc_result[63:32];
        temp_lo <= calc_dbz ? lo_q : calc_result[31:0];
        count   <= is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        busy_q  <= 1'b1;
      end else if (bus.mdu_op == MDU_MTHI) begin
        hi_q <= bus.a;
      end else if (bus.mdu_op == MDU_MTLO) begin
        lo_q <= bus.a;
      end
    end
  end

  assign bus.start = is_md_op(bus.mdu_op);
  assign bus.busy  = busy_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

  always_comb begin
    bus.mdu_out = 32'd0;
    if (bus.mdu_op == MDU_MFHI)      bus.mdu_out = hi_q;
    else if (bus.mdu_op == MDU_MFLO) bus.mdu_out = lo_q;
  end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed test-plan cases followed by random
// traffic, all compared every cycle against a behavioural HI/LO model.
module tb_mdu;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  mdu_if bus ();

  mdu dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  logic [31:0] m_pend_hi = 32'd0, m_pend_lo = 32'd0;
  bit          m_pend_valid = 1'b0;
  int          m_left = 0;

  // Last sampled DUT outputs
  logic        s_busy, s_start;
  logic [31:0] s_hi, s_lo, s_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic rst, input logic [3:0] op,
                              input logic [31:0] a, input logic [31:0] b);
    longint sp, sa, sb, q, r;
    longint unsigned up;
    if (rst) begin
      m_hi = 0; m_lo = 0; m_left = 0; m_pend_valid = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_pend_valid) begin
        m_hi = m_pend_hi;
        m_lo = m_pend_lo;
      end
    end else begin
      case (op)
        MDU_MULT: begin
          sp = longint'($signed(a)) * longint'($signed(b));
          m_pend_hi = sp[63:32]; m_pend_lo = sp[31:0];
          m_pend_valid = 1; m_left = 5;
        end
        MDU_MULTU: begin
          up = longint'({32'd0, a}) * longint'({32'd0, b});
          m_pend_hi = up[63:32]; m_pend_lo = up[31:0];
          m_pend_valid = 1; m_left = 5;
        end
        MDU_DIV: begin
          m_left = 10;
          m_pend_valid = (b != 0);
          if (b != 0) begin
            sa = longint'($signed(a)); sb = longint'($signed(b));
            q = sa / sb; r = sa % sb;
            m_pend_lo = q[31:0]; m_pend_hi = r[31:0];
          end
        end
        MDU_DIVU: begin
          m_left = 10;
          m_pend_valid = (b != 0);
          if (b != 0) begin
            m_pend_lo = a / b; m_pend_hi = a % b;
          end
        end
        MDU_MTHI: m_hi = a;
        MDU_MTLO: m_lo = a;
        default: ;
      endcase
    end
  endtask

  // Drive one cycle of inputs, compare all outputs against the model, advance.
  task automatic step(input logic rst, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp_out;
    logic        exp_start;
    @(negedge clk);
    reset = rst; bus.mdu_op = op; bus.a = a; bus.b = b;
    #1;
    s_busy = bus.busy; s_start = bus.start;
    s_hi = bus.hi; s_lo = bus.lo; s_out = bus.mdu_out;
    exp_start = (op >= 4'd1) && (op <= 4'd4);
    exp_out = (op == MDU_MFHI) ? m_hi : (op == MDU_MFLO) ? m_lo : 32'd0;
    check("busy", {31'd0, s_busy}, {31'd0, m_left > 0});
    check("start", {31'd0, s_start}, {31'd0, exp_start});
    check("hi", s_hi, m_hi);
    check("lo", s_lo, m_lo);
    check("mdu_out", s_out, exp_out);
    @(posedge clk);
    model_update(rst, op, a, b);
  endtask

  // Idle until Busy is sampled low; returns number of Busy-high cycles seen.
  task automatic wait_idle(output int n);
    int guard = 0;
    n = 0;
    do begin
      step(1'b0, MDU_NONE, 32'd0, 32'd0);
      if (s_busy) n++;
      guard++;
    end while (s_busy && guard < 40);
    check("idle_timeout", 32'(guard < 40), 32'd1);
  endtask

  initial begin
    int n;
    logic [3:0] op;
    logic [31:0] ra, rb;
    bus.a = 0; bus.b = 0; bus.mdu_op = MDU_NONE;
    repeat (2) @(posedge clk);

    step(1'b1, MDU_NONE, 0, 0);
    step(1'b0, MDU_NONE, 0, 0);
    check("reset_hi", s_hi, 32'd0);
    check("reset_busy", {31'd0, s_busy}, 32'd0);

    // MULT -2 * 3
    step(1'b0, MDU_MULT, 32'hFFFFFFFE, 32'd3);
    wait_idle(n);
    check("mult_busy_cycles", 32'(n), 32'd5);
    check("mult_hi", s_hi, 32'hFFFFFFFF);
    check("mult_lo", s_lo, 32'hFFFFFFFA);
    step(1'b0, MDU_MFHI, 0, 0);
    check("mfhi", s_out, 32'hFFFFFFFF);
    step(1'b0, MDU_MFLO, 0, 0);
    check("mflo", s_out, 32'hFFFFFFFA);

    // MULTU max * max
    step(1'b0, MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle(n);
    check("multu_hi", s_hi, 32'hFFFFFFFE);
    check("multu_lo", s_lo, 32'h00000001);

    // DIV -7 / 2, DIVU 7 / 2, DIV overflow case
    step(1'b0, MDU_DIV, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    check("div_busy_cycles", 32'(n), 32'd10);
    check("div_lo", s_lo, 32'hFFFFFFFD);
    check("div_hi", s_hi, 32'hFFFFFFFF);
    step(1'b0, MDU_DIVU, 32'd7, 32'd2);
    wait_idle(n);
    check("divu_lo", s_lo, 32'd3);
    check("divu_hi", s_hi, 32'd1);
    step(1'b0, MDU_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    check("div_ovf_lo", s_lo, 32'h80000000);
    check("div_ovf_hi", s_hi, 32'd0);

    // MTHI/MTLO then divide by zero
    step(1'b0, MDU_MTHI, 32'h12345678, 0);
    step(1'b0, MDU_MTLO, 32'h9ABCDEF0, 0);
    check("mthi_hi", s_hi, 32'h12345678);
    check("mthi_busy", {31'd0, s_busy}, 32'd0);
    step(1'b0, MDU_DIV, 32'd55, 32'd0);
    check("mtlo_lo", s_lo, 32'h9ABCDEF0);
    wait_idle(n);
    check("dbz_busy_cycles", 32'(n), 32'd10);
    check("dbz_hi", s_hi, 32'h12345678);
    check("dbz_lo", s_lo, 32'h9ABCDEF0);

    // Ops presented while busy are ignored
    step(1'b0, MDU_MULT, 32'd7, 32'd6);
    step(1'b0, MDU_MULT, 32'd100, 32'd100);
    step(1'b0, MDU_MTHI, 32'hDEADBEEF, 0);
    wait_idle(n);
    check("busy_ignore_cycles", 32'(n + 2), 32'd5);
    check("busy_ignore_hi", s_hi, 32'd0);
    check("busy_ignore_lo", s_lo, 32'd42);

    // Reset in the 4th Busy cycle aborts the divide
    step(1'b0, MDU_DIV, 32'd100, 32'd7);
    repeat (3) step(1'b0, MDU_NONE, 0, 0);
    step(1'b1, MDU_NONE, 0, 0);
    step(1'b0, MDU_NONE, 0, 0);
    check("abort_busy", {31'd0, s_busy}, 32'd0);
    check("abort_lo", s_lo, 32'd0);
    repeat (12) step(1'b0, MDU_NONE, 0, 0);
    check("abort_no_write_lo", s_lo, 32'd0);
    check("abort_no_write_hi", s_hi, 32'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      op = 4'($urandom_range(0, 15));
      ra = $urandom();
      rb = $urandom();
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      step($urandom_range(0, 79) == 0, op, ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
